// File: rtl/regfile_wb_arb.sv
// Round-robin arbiter sharing the regfile write port among four requesters.
// Grant is combinational in the request cycle, write registers are valid the next cycle; stall suppresses grants.
module regfile_wb_arb #(
    parameter int NREQ     = 4,
    parameter int DataSize = 32,
    parameter int AddrSize = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AddrSize-1:0] req_addr,
    input  logic [NREQ*DataSize-1:0] req_data,
    input  logic                     stall,
    output logic [NREQ-1:0]          gnt,
    output logic                     reg_enable,
    output logic                     reg_write,
    output logic [AddrSize-1:0]      write_addr,
    output logic [DataSize-1:0]      write_data,
    output logic [NREQ*8-1:0]        grant_cnt
);
    logic [1:0] ptr;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       grant_any;

    // Search starts at ptr and wraps; the first requesting index wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any = found && !stall && !rst;
        gnt       = '0;
        if (grant_any) begin
            gnt[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 2'd0;
            reg_enable <= 1'b0;
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            grant_cnt  <= '0;
        end else begin
            reg_enable <= 1'b1;
            reg_write  <= grant_any;
            if (grant_any) begin
                ptr        <= winner + 2'd1;
                write_addr <= req_addr[winner*AddrSize +: AddrSize];
                write_data <= req_data[winner*DataSize +: DataSize];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && grant_cnt[i*8 +: 8] != 8'hff) begin
                    grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomized and directed bench for regfile_wb_arb with a scoreboard on the write port
// and a behavioural regfile fed by the arbiter outputs.
module tb_regfile_wb_arb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [23:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic         stall = 1'b0;
    logic [3:0]   gnt;
    logic         reg_enable;
    logic         reg_write;
    logic [5:0]   write_addr;
    logic [31:0]  write_data;
    logic [31:0]  grant_cnt;

    regfile_wb_arb dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .stall(stall), .gnt(gnt), .reg_enable(reg_enable), .reg_write(reg_write),
        .write_addr(write_addr), .write_data(write_data), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // requester-side state
    bit          p_req [4];
    logic [5:0]  p_addr[4];
    logic [31:0] p_data[4];

    // reference model state
    int          m_ptr = 0;
    int          m_cnt [4];
    logic [31:0] m_mem [64];
    bit          m_rw = 0;
    bit          m_en = 0;
    bit          known = 0;
    bit          pend_v = 0;
    logic [5:0]  pend_a;
    logic [31:0] pend_d;
    int          last_win = -1;
    logic [37:0] q[$];

    logic [31:0] mem_dut [64] = '{default: 32'h0};

    // downstream regfile: a write presented during a reset cycle is lost
    always @(posedge clk) begin
        if (reg_write === 1'b1 && rst === 1'b0) mem_dut[write_addr] <= write_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: every presented write must match the oldest outstanding grant
    always @(negedge clk) begin
        if (known && rst === 1'b0 && reg_write === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=%h required=none", {write_addr, write_data});
            end else begin
                logic [37:0] e;
                e = q.pop_front();
                check("wb_addr_data", {26'h0, write_addr, write_data}, {26'h0, e});
            end
        end
    end

    task automatic model_eval();
        logic [3:0]  eg;
        logic [31:0] ec;
        int w;
        eg = '0;
        w  = -1;
        if (!rst && !stall) begin
            for (int d = 0; d < 4; d++) begin
                int i;
                i = (m_ptr + d) % 4;
                if (w < 0 && p_req[i]) w = i;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        check("gnt", {60'h0, gnt}, {60'h0, eg});
        if (known) begin
            ec = '0;
            for (int i = 0; i < 4; i++) ec[i*8 +: 8] = 8'(m_cnt[i]);
            check("reg_write", {63'h0, reg_write}, {63'h0, m_rw});
            check("reg_enable", {63'h0, reg_enable}, {63'h0, m_en});
            check("grant_cnt", {32'h0, grant_cnt}, {32'h0, ec});
        end
        if (pend_v && !rst) m_mem[pend_a] = pend_d;
        pend_v = 0;
        if (rst) begin
            m_ptr = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            q.delete();
            m_rw  = 0;
            m_en  = 0;
            known = 1;
        end else begin
            m_en = 1;
            m_rw = (w >= 0);
            if (w >= 0) begin
                q.push_back({p_addr[w], p_data[w]});
                pend_v = 1;
                pend_a = p_addr[w];
                pend_d = p_data[w];
                m_ptr  = (w + 1) % 4;
                if (m_cnt[w] < 255) m_cnt[w]++;
            end
        end
        last_win = w;
    endtask

    task automatic step(input logic s, input logic r);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            req[i] = p_req[i];
            req_addr[i*6 +: 6] = p_addr[i];
            req_data[i*32 +: 32] = p_data[i];
        end
        stall = s;
        rst = r;
        @(negedge clk);
        model_eval();
    endtask

    task automatic set_req(input int i, input bit v, input logic [5:0] a, input logic [31:0] d);
        p_req[i] = v;
        p_addr[i] = a;
        p_data[i] = d;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) p_req[i] = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] d3_last;
        int ndiff;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            set_req(i, 0, 6'd0, 32'h0);
        end

        // reset, then a single request
        do_reset();
        set_req(0, 1, 6'd12, 32'hffff_0001);
        step(1'b0, 1'b0);
        check("single_gnt", {60'h0, gnt}, 64'h1);
        p_req[0] = 0;
        step(1'b0, 1'b0);
        check("single_waddr", {58'h0, write_addr}, 64'd12);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("single_read", {32'h0, mem_dut[12]}, 64'hffff_0001);

        // all four requesting for 8 cycles
        do_reset();
        set_req(0, 1, 6'd0, $urandom);
        set_req(1, 1, 6'd25, $urandom);
        set_req(2, 1, 6'd51, $urandom);
        set_req(3, 1, 6'd63, $urandom);
        d3_last = 32'h0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            check("rr_order", {60'h0, gnt}, 64'h1 << (k % 4));
            if (k % 4 == 3) d3_last = p_data[3];
            if (last_win >= 0) p_data[last_win] = $urandom;
        end
        for (int i = 0; i < 4; i++) p_req[i] = 0;
        step(1'b0, 1'b0);
        check("rr_counts", {32'h0, grant_cnt}, 64'h0202_0202);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rr_reg63", {32'h0, mem_dut[63]}, {32'h0, d3_last});

        // stall with requesters 1 and 2
        set_req(1, 1, 6'd33, 32'h1111_0001);
        set_req(2, 1, 6'd34, 32'h2222_0002);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            check("stall_gnt", {60'h0, gnt}, 64'h0);
        end
        step(1'b0, 1'b0);
        check("stall_rw", {63'h0, reg_write}, 64'h0);
        check("post_stall_gnt1", {60'h0, gnt}, 64'h2);
        p_req[1] = 0;
        step(1'b0, 1'b0);
        check("post_stall_gnt2", {60'h0, gnt}, 64'h4);
        p_req[2] = 0;
        step(1'b0, 1'b0);

        // same address from requesters 2 and 3 with ptr at 2
        do_reset();
        set_req(1, 1, 6'd40, 32'h0000_0040);
        step(1'b0, 1'b0);
        p_req[1] = 0;
        set_req(2, 1, 6'd41, 32'hA);
        set_req(3, 1, 6'd41, 32'hB);
        step(1'b0, 1'b0);
        check("same_addr_first", {60'h0, gnt}, 64'h4);
        p_req[2] = 0;
        step(1'b0, 1'b0);
        check("same_addr_second", {60'h0, gnt}, 64'h8);
        p_req[3] = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("same_addr_reg41", {32'h0, mem_dut[41]}, 64'hB);

        // reset the cycle after a grant, with another request held across it
        do_reset();
        set_req(0, 1, 6'd7, 32'hdead_0007);
        set_req(1, 1, 6'd8, 32'hbeef_0008);
        step(1'b0, 1'b0);
        check("mid_rst_grant", {60'h0, gnt}, 64'h1);
        p_req[0] = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("mid_rst_rw", {63'h0, reg_write}, 64'h0);
        check("mid_rst_cnt", {32'h0, grant_cnt}, 64'h0);
        check("mid_rst_held", {60'h0, gnt}, 64'h2);
        p_req[1] = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("mid_rst_dropped", {32'h0, mem_dut[7]}, 64'h0);
        check("mid_rst_held_wr", {32'h0, mem_dut[8]}, 64'hbeef_0008);

        // saturation
        do_reset();
        set_req(0, 1, 6'd3, $urandom);
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b0);
            p_data[0] = $urandom;
        end
        p_req[0] = 0;
        step(1'b0, 1'b0);
        check("sat_cnt", {32'h0, grant_cnt}, 64'h0000_00ff);
        step(1'b0, 1'b0);

        // randomized traffic with stalls and occasional resets
        for (int k = 0; k < 600; k++) begin
            logic s, r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 59) == 0);
            step(s, r);
            if (last_win >= 0) begin
                set_req(last_win, bit'($urandom_range(0, 1)), 6'($urandom), $urandom);
            end
            for (int i = 0; i < 4; i++) begin
                if (!p_req[i] && i != last_win && $urandom_range(0, 9) < 4)
                    set_req(i, 1, 6'($urandom), $urandom);
            end
        end
        for (int i = 0; i < 4; i++) p_req[i] = 0;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);

        check("sb_drained", 64'(q.size()), 64'h0);
        ndiff = 0;
        for (int i = 0; i < 64; i++) if (mem_dut[i] !== m_mem[i]) ndiff++;
        check("regfile_contents", 64'(ndiff), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
